hazard_track_unit: RTL and testbench

- Producer end of the pipeline forwarding interface.
- Tracks destination register, write enable and load flag of in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the ex_mem_rd/ex_mem_wen/mem_wb_rd/mem_wb_wen bundle consumed by the forwarding unit.
- Detects load-use hazards that forwarding cannot cover and stalls the front end for exactly one cycle, inserting a bubble into ID/EX.

---
 rtl/hazard_track_unit_if.sv | 10 +
 rtl/hazard_track_unit.sv | 58 +++++
 tb/tb_hazard_track_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_track_unit_if.sv
// hazard_track_unit_if: forwarding bundle driven by the hazard tracker (master)
// and consumed by the forwarding unit (slave).
interface hazard_track_unit_if #(parameter int REG_W = 5);
   logic [REG_W-1:0] ex_mem_rd;
   logic             ex_mem_wen;
   logic [REG_W-1:0] mem_wb_rd;
   logic             mem_wb_wen;
   modport master (output ex_mem_rd, ex_mem_wen, mem_wb_rd, mem_wb_wen);
   modport slave (input ex_mem_rd, ex_mem_wen, mem_wb_rd, mem_wb_wen);
endinterface

// File: rtl/hazard_track_unit.sv
// hazard_track_unit: tracks rd/wen/load through ID/EX..MEM/WB and inserts one-cycle load-use stalls.
// Optional macro STALL_CNT_EN builds a saturating load-use stall counter on stall_cnt.
module hazard_track_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_wen,
   input  logic             id_mem_read,
   input  logic             flush,
   input  logic             ext_stall,
   hazard_track_unit_if.master fwd,
   output logic [REG_W-1:0] id_ex_rd,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic {RUN, STALL} state_t;
   state_t state;
   logic idex_wen, idex_mem_read, hazard, stall_go, bubble;
   assign hazard = id_valid & idex_mem_read & idex_wen & ((id_ex_rd == id_rs) | (id_ex_rd == id_rt));
   assign stall_go = hazard & ~flush & ~ext_stall & (state == RUN);
   assign bubble = ~id_valid | flush | stall_go;
   assign pc_write_en = ~ext_stall & ~stall_go;
   assign if_id_write_en = ~ext_stall & ~stall_go;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= RUN;
         id_ex_rd       <= '0;
         idex_wen       <= 1'b0;
         idex_mem_read  <= 1'b0;
         fwd.ex_mem_rd  <= '0;
         fwd.ex_mem_wen <= 1'b0;
         fwd.mem_wb_rd  <= '0;
         fwd.mem_wb_wen <= 1'b0;
      end else if (!ext_stall) begin
         state          <= stall_go ? STALL : RUN;
         fwd.mem_wb_rd  <= fwd.ex_mem_rd;
         fwd.mem_wb_wen <= fwd.ex_mem_wen;
         fwd.ex_mem_rd  <= id_ex_rd;
         fwd.ex_mem_wen <= idex_wen;
         id_ex_rd       <= bubble ? '0 : id_rd;
         idex_wen       <= ~bubble & id_wen & (id_rd != '0);
         idex_mem_read  <= ~bubble & id_mem_read;
      end
`ifdef STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_cnt <= '0;
      else if (stall_go && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_track_unit.sv
// tb_hazard_track_unit: directed scenarios plus randomized traffic against a pipeline-list model.
module tb_hazard_track_unit;
   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid = 1'b0, id_wen = 1'b0, id_mem_read = 1'b0, flush = 1'b0, ext_stall = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0, id_ex_rd;
   logic pc_write_en, if_id_write_en;
   logic [15:0] stall_cnt;
   int total = 0, bad = 0;
   hazard_track_unit_if #(.REG_W(5)) fwd ();
   hazard_track_unit #(.REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_wen(id_wen), .id_mem_read(id_mem_read), .flush(flush),
      .ext_stall(ext_stall), .fwd(fwd), .id_ex_rd(id_ex_rd), .pc_write_en(pc_write_en),
      .if_id_write_en(if_id_write_en), .stall_cnt(stall_cnt));
   always #5 clk = ~clk;

   typedef struct packed { logic [4:0] rd; logic wen; logic ld; } entry_t;
   entry_t pipe [3];
   logic [15:0] m_cnt;

   function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef STALL_CNT_EN
      return c;
`else
      return 16'd0;
`endif
   endfunction

   function automatic bit m_hazard();
      return !ext_stall && id_valid && pipe[0].ld && pipe[0].wen &&
             (pipe[0].rd == id_rs || pipe[0].rd == id_rt);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_cnt = '0;
   endtask

   task automatic tick();
      bit hz;
      entry_t e;
      hz = m_hazard() && !flush;
      @(posedge clk);
      if (!rst_n) m_reset();
      else if (!ext_stall) begin
         if (hz && m_cnt != 16'hffff) m_cnt++;
         e = '0;
         if (id_valid && !flush && !hz) e = '{id_rd, id_wen && id_rd != 0, id_mem_read};
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, rt, rd, input logic w, ld, fl, es);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_wen = w; id_mem_read = ld; flush = fl; ext_stall = es;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         tick();
      end
      total++;
      if ({id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen, fwd.mem_wb_rd, fwd.mem_wb_wen, pc_write_en, if_id_write_en, stall_cnt} !== {18'h3, 16'h0}) begin
         bad++; $display("FAIL reset_values got id_ex=%0d exm=%0d/%0b mwb=%0d/%0b pc=%0b ifid=%0b cnt=%0d want 0 0/0 0/0 1 1 0",
            id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen, fwd.mem_wb_rd, fwd.mem_wb_wen, pc_write_en, if_id_write_en, stall_cnt);
      end
      drive(1, 0, 0, 5, 1, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      total++;
      if (id_ex_rd !== 5'd5) begin bad++; $display("FAIL first_idex got %0d want 5", id_ex_rd); end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      total++;
      if ({fwd.ex_mem_rd, fwd.ex_mem_wen} !== {5'd5, 1'b1}) begin
         bad++; $display("FAIL first_exmem got %0d/%0b want 5/1", fwd.ex_mem_rd, fwd.ex_mem_wen); end
      tick();
      total++;
      if ({fwd.mem_wb_rd, fwd.mem_wb_wen} !== {5'd5, 1'b1}) begin
         bad++; $display("FAIL first_memwb got %0d/%0b want 5/1", fwd.mem_wb_rd, fwd.mem_wb_wen); end
   endtask

   task automatic test_load_use();
      logic [15:0] c0;
      c0 = stall_cnt;
      drive(1, 0, 0, 8, 1, 1, 0, 0);
      tick();
      drive(1, 8, 1, 9, 1, 0, 0, 0);
      total++;
      if ({pc_write_en, if_id_write_en} !== 2'b00) begin
         bad++; $display("FAIL loaduse_stall got pc=%0b ifid=%0b want 0 0", pc_write_en, if_id_write_en); end
      tick();
      total++;
      if ({pc_write_en, id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen} !== {1'b1, 5'd0, 5'd8, 1'b1}) begin
         bad++; $display("FAIL loaduse_bubble got pc=%0b idex=%0d exm=%0d/%0b want 1 0 8/1",
            pc_write_en, id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen); end
      total++;
      if (stall_cnt !== cnt_exp(c0 + 16'd1)) begin
         bad++; $display("FAIL loaduse_cnt got %0d want %0d", stall_cnt, cnt_exp(c0 + 16'd1)); end
      tick();
      total++;
      if ({id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen} !== {5'd9, 5'd0, 1'b0}) begin
         bad++; $display("FAIL loaduse_follow got idex=%0d exm=%0d/%0b want 9 0/0", id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen); end
   endtask

   task automatic test_r0_nonload();
      drive(1, 0, 0, 0, 1, 1, 0, 0);
      tick();
      drive(1, 0, 0, 2, 1, 0, 0, 0);
      total++;
      if (pc_write_en !== 1'b1) begin bad++; $display("FAIL r0_nostall got pc=%0b want 1", pc_write_en); end
      tick();
      total++;
      if (fwd.ex_mem_wen !== 1'b0) begin bad++; $display("FAIL r0_wen got %0b want 0", fwd.ex_mem_wen); end
      drive(1, 0, 0, 8, 1, 0, 0, 0);
      tick();
      drive(1, 8, 8, 1, 1, 0, 0, 0);
      total++;
      if (if_id_write_en !== 1'b1) begin bad++; $display("FAIL alu_nostall got ifid=%0b want 1", if_id_write_en); end
      tick();
   endtask

   task automatic test_flush();
      logic [15:0] c0;
      drive(1, 0, 0, 3, 1, 1, 0, 0);
      tick();
      c0 = stall_cnt;
      drive(1, 0, 3, 7, 1, 0, 1, 0);
      total++;
      if ({pc_write_en, if_id_write_en} !== 2'b11) begin
         bad++; $display("FAIL flush_enables got pc=%0b ifid=%0b want 1 1", pc_write_en, if_id_write_en); end
      tick();
      total++;
      if ({id_ex_rd, stall_cnt} !== {5'd0, c0}) begin
         bad++; $display("FAIL flush_bubble got idex=%0d cnt=%0d want 0 %0d", id_ex_rd, stall_cnt, c0); end
   endtask

   task automatic test_ext_stall();
      logic [34:0] snap;
      logic [15:0] c0;
      drive(1, 0, 0, 4, 1, 1, 0, 0);
      tick();
      c0 = stall_cnt;
      drive(1, 4, 0, 6, 1, 0, 0, 1);
      snap = {id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen, fwd.mem_wb_rd, fwd.mem_wb_wen, 2'b00, stall_cnt};
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen, fwd.mem_wb_rd, fwd.mem_wb_wen, pc_write_en, if_id_write_en, stall_cnt} !== snap) begin
            bad++; $display("FAIL extstall_freeze cycle %0d got idex=%0d exm=%0d pc=%0b want idex=%0d exm=%0d pc=0",
               i, id_ex_rd, fwd.ex_mem_rd, pc_write_en, snap[34:30], snap[29:25]); end
      end
      drive(1, 4, 0, 6, 1, 0, 0, 0);
      total++;
      if (pc_write_en !== 1'b0) begin bad++; $display("FAIL extstall_release got pc=%0b want 0", pc_write_en); end
      tick();
      total++;
      if ({pc_write_en, stall_cnt} !== {1'b1, cnt_exp(c0 + 16'd1)}) begin
         bad++; $display("FAIL extstall_single got pc=%0b cnt=%0d want 1 %0d", pc_write_en, stall_cnt, cnt_exp(c0 + 16'd1)); end
      tick();
   endtask

   task automatic test_async_reset();
      drive(1, 0, 0, 6, 1, 1, 0, 0);
      tick();
      drive(1, 6, 0, 2, 1, 0, 0, 0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen, fwd.mem_wb_rd, fwd.mem_wb_wen, pc_write_en, if_id_write_en, stall_cnt} !== {18'h3, 16'h0}) begin
         bad++; $display("FAIL async_reset got exm=%0d/%0b pc=%0b cnt=%0d want 0/0 1 0", fwd.ex_mem_rd, fwd.ex_mem_wen, pc_write_en, stall_cnt); end
      m_reset();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [34:0] act, exp;
      bit en;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
         en = !ext_stall && !(m_hazard() && !flush);
         exp = {pipe[0].rd, pipe[1].rd, pipe[1].wen, pipe[2].rd, pipe[2].wen, en, en, cnt_exp(m_cnt)};
         act = {id_ex_rd, fwd.ex_mem_rd, fwd.ex_mem_wen, fwd.mem_wb_rd, fwd.mem_wb_wen, pc_write_en, if_id_write_en, stall_cnt};
         total++;
         if (act !== exp) begin bad++; $display("FAIL random cycle %0d got %h want %h", i, act, exp); end
         tick();
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_load_use();
      test_r0_nonload();
      test_flush();
      test_ext_stall();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
